// File: rtl/npc_bpu_pkg.sv
// Shared constants and types for the next-PC / branch prediction unit:
// counter states, default reset PC, instruction-type encodings, D-stage resolution record.
package npc_bpu_pkg;

  localparam logic [31:0] BPU_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } cnt_e;

  typedef logic [9:0] instr_t;

  localparam instr_t IT_NONE    = 10'b00_0000_0000;
  localparam instr_t IT_BEQ     = 10'b00_0000_0001;
  localparam instr_t IT_BSVEALL = 10'b00_0000_0010;
  localparam instr_t IT_JAL     = 10'b00_0000_0100;
  localparam instr_t IT_JR      = 10'b00_0000_1000;

  typedef struct packed {
    logic        ctl;
    logic        taken;
    logic [31:0] target;
    logic [31:0] resolved;
  } dres_t;

  // Two-bit saturating counter step toward the observed outcome.
  function automatic cnt_e cnt_step(cnt_e c, logic taken);
    cnt_e n;
    n = c;
    case (c)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      ST:      n = taken ? ST  : WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/npc_bpu_if.sv
// Pipeline-facing signals of npc_bpu: F-stage fetch/prediction, D-stage resolution
// inputs and the late-stage redirect.
interface npc_bpu_if;
  logic        F_stall;
  logic [31:0] F_PC;
  logic        F_predTaken;
  logic [31:0] F_predTarget;
  logic        D_valid;
  logic [31:0] D_PC;
  logic [9:0]  D_inStrType;
  logic        D_isBranch;
  logic [25:0] D_imm;
  logic [31:0] D_RD1;
  logic        D_predTaken;
  logic [31:0] D_predTarget;
  logic        X_redirect;
  logic [31:0] X_target;
  logic        D_flush;
  logic [31:0] D_link;

  modport master (
    output F_stall, D_valid, D_PC, D_inStrType, D_isBranch, D_imm, D_RD1,
           D_predTaken, D_predTarget, X_redirect, X_target,
    input  F_PC, F_predTaken, F_predTarget, D_flush, D_link
  );

  modport slave (
    input  F_stall, D_valid, D_PC, D_inStrType, D_isBranch, D_imm, D_RD1,
           D_predTaken, D_predTarget, X_redirect, X_target,
    output F_PC, F_predTaken, F_predTarget, D_flush, D_link
  );
endinterface

// File: rtl/npc_btb.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// edge-triggered update from the resolving D-stage instruction.
module npc_btb
  import npc_bpu_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rd_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_tgt_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_pc_i,
  input  logic        wr_taken_i,
  input  logic [31:0] wr_tgt_i
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDX;

  logic [ENTRIES-1:0]            vld_q;
  logic [ENTRIES-1:0][TAGW-1:0]  tag_q;
  logic [ENTRIES-1:0][31:0]      tgt_q;
  cnt_e                          cnt_q [ENTRIES];

  logic [IDX-1:0]  ridx, widx;
  logic [TAGW-1:0] rtag, wtag;
  logic            rhit, whit;

  assign ridx = rd_pc_i[IDX+1:2];
  assign rtag = rd_pc_i[31:IDX+2];
  assign widx = wr_pc_i[IDX+1:2];
  assign wtag = wr_pc_i[31:IDX+2];

  assign rhit         = vld_q[ridx] && (tag_q[ridx] == rtag);
  assign pred_taken_o = rhit && (cnt_q[ridx] inside {WT, ST});
  assign pred_tgt_o   = tgt_q[ridx];

  assign whit = vld_q[widx] && (tag_q[widx] == wtag);

  logic unused_lsb;
  assign unused_lsb = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  // Reads see the pre-edge entry; a write lands on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      tag_q <= '0;
      tgt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= WNT;
    end else if (wr_en_i) begin
      if (whit) begin
        cnt_q[widx] <= cnt_step(cnt_q[widx], wr_taken_i);
        if (wr_taken_i) tgt_q[widx] <= wr_tgt_i;
      end else if (wr_taken_i) begin
        vld_q[widx] <= 1'b1;
        tag_q[widx] <= wtag;
        tgt_q[widx] <= wr_tgt_i;
        cnt_q[widx] <= WT;
      end
    end
  end

endmodule

// File: rtl/npc_bpu.sv
// Next-PC unit: owns the fetch PC, resolves control flow in D, and either follows
// delay-slot semantics or predicts with a BTB and flushes on a D-stage mispredict.
module npc_bpu
  import npc_bpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = BPU_RESET_PC,
  parameter int          BTB_ENTRIES = 16,
  parameter bit          DELAY_SLOT  = 1'b1
) (
  input logic       clk,
  input logic       reset,
  npc_bpu_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic        pred_taken;
  logic [31:0] pred_tgt;
  logic        flush;
  logic        mis;
  logic        btb_we;
  logic        is_br, is_jal, is_jr;
  logic [31:0] d_seq, br_tgt, jal_tgt;
  dres_t       dr;

  assign is_br  = (bus.D_inStrType == IT_BEQ) || (bus.D_inStrType == IT_BSVEALL);
  assign is_jal = (bus.D_inStrType == IT_JAL);
  assign is_jr  = (bus.D_inStrType == IT_JR);

  assign d_seq   = bus.D_PC + 32'd4;
  assign br_tgt  = d_seq + {{14{bus.D_imm[15]}}, bus.D_imm[15:0], 2'b00};
  assign jal_tgt = {bus.D_PC[31:28], bus.D_imm, 2'b00};

  // Bubbles never resolve as taken, so a stale type field in D cannot redirect.
  always_comb begin
    dr          = '0;
    dr.ctl      = bus.D_valid & (is_br | is_jal | is_jr);
    dr.taken    = bus.D_valid & ((is_br & bus.D_isBranch) | is_jal | is_jr);
    dr.target   = is_jr ? bus.D_RD1 : (is_jal ? jal_tgt : br_tgt);
    dr.resolved = dr.taken ? dr.target : d_seq;
  end

  // A non-control instruction that was predicted taken (BTB alias) is also a mispredict.
  assign mis = !DELAY_SLOT &&
               (dr.ctl ? ((bus.D_predTaken != dr.taken) ||
                          (dr.taken && (bus.D_predTarget != dr.target)))
                       : (bus.D_valid && bus.D_predTaken));

  assign btb_we = !DELAY_SLOT && dr.ctl && !bus.F_stall && !bus.X_redirect;

  always_comb begin
    pc_d  = pc_q + 32'd4;
    flush = 1'b0;
    if (bus.X_redirect) begin
      pc_d = bus.X_target;
    end else if (bus.F_stall) begin
      pc_d = pc_q;
    end else if (DELAY_SLOT) begin
      if (dr.taken) pc_d = dr.target;
    end else if (mis) begin
      pc_d  = dr.resolved;
      flush = 1'b1;
    end else if (pred_taken) begin
      pc_d = pred_tgt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  generate
    if (!DELAY_SLOT) begin : g_btb
      npc_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .reset        (reset),
        .rd_pc_i      (pc_q),
        .pred_taken_o (pred_taken),
        .pred_tgt_o   (pred_tgt),
        .wr_en_i      (btb_we),
        .wr_pc_i      (bus.D_PC),
        .wr_taken_i   (dr.taken),
        .wr_tgt_i     (dr.target)
      );
    end else begin : g_nobtb
      assign pred_taken = 1'b0;
      assign pred_tgt   = pc_q + 32'd4;
      logic unused_pred;
      assign unused_pred = ^{bus.D_predTaken, bus.D_predTarget, btb_we, dr.resolved};
    end
  endgenerate

  assign bus.F_PC         = pc_q;
  assign bus.F_predTaken  = pred_taken;
  assign bus.F_predTarget = pred_tgt;
  assign bus.D_flush      = flush;
  assign bus.D_link       = bus.D_PC + (DELAY_SLOT ? 32'd8 : 32'd4);

endmodule

// File: tb/tb_npc_bpu.sv
// Directed bench for npc_bpu: one predicting unit and one delay-slot unit share
// stimulus; a behavioural model is compared every cycle alongside literal checks.
module tb_npc_bpu;
  import npc_bpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        F_stall = 0, D_valid = 0, D_isBranch = 0, D_predTaken = 0, X_redirect = 0;
  logic [31:0] D_PC = 0, D_RD1 = 0, D_predTarget = 0, X_target = 0;
  logic [9:0]  D_type = IT_NONE;
  logic [25:0] D_imm = 0;

  // index 0: DELAY_SLOT=0 (predicting), index 1: DELAY_SLOT=1
  npc_bpu_if ifs[2] ();
  logic [31:0] o_pc[2], o_ptgt[2], o_link[2];
  logic        o_pt[2], o_fl[2];

  for (genvar g = 0; g < 2; g++) begin : g_drv
    assign ifs[g].F_stall      = F_stall;
    assign ifs[g].D_valid      = D_valid;
    assign ifs[g].D_PC         = D_PC;
    assign ifs[g].D_inStrType  = D_type;
    assign ifs[g].D_isBranch   = D_isBranch;
    assign ifs[g].D_imm        = D_imm;
    assign ifs[g].D_RD1        = D_RD1;
    assign ifs[g].D_predTaken  = D_predTaken;
    assign ifs[g].D_predTarget = D_predTarget;
    assign ifs[g].X_redirect   = X_redirect;
    assign ifs[g].X_target     = X_target;
    assign o_pc[g]   = ifs[g].F_PC;
    assign o_pt[g]   = ifs[g].F_predTaken;
    assign o_ptgt[g] = ifs[g].F_predTarget;
    assign o_fl[g]   = ifs[g].D_flush;
    assign o_link[g] = ifs[g].D_link;
  end

  npc_bpu #(.DELAY_SLOT(1'b0)) u_nd (.clk(clk), .reset(reset), .bus(ifs[0]));
  npc_bpu #(.DELAY_SLOT(1'b1)) u_ds (.clk(clk), .reset(reset), .bus(ifs[1]));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit v; int unsigned tag; int unsigned tgt; int cnt; } ent_t;
  typedef struct { bit ctl; bit tk; int unsigned tgt; } res_t;
  typedef struct { int unsigned npc; bit flush; bit pt; int unsigned ptgt; int unsigned link; } exp_t;

  ent_t        btb[16];
  int unsigned m_pc[2];
  exp_t        x0, x1;
  res_t        rr;

  function automatic res_t resolve();
    res_t r;
    bit isb, isj, isr;
    int signed off;
    isb = (D_type == IT_BEQ) || (D_type == IT_BSVEALL);
    isj = (D_type == IT_JAL);
    isr = (D_type == IT_JR);
    off = $signed(D_imm[15:0]);
    r.ctl = D_valid && (isb || isj || isr);
    r.tk  = D_valid && ((isb && D_isBranch) || isj || isr);
    if (isr)      r.tgt = D_RD1;
    else if (isj) r.tgt = (D_PC & 32'hF000_0000) + D_imm * 4;
    else          r.tgt = D_PC + 4 + off * 4;
    return r;
  endfunction

  function automatic exp_t model_out(int m);
    exp_t e;
    res_t r;
    bit mis;
    int unsigned i;
    r = resolve();
    i = (m_pc[0] / 4) % 16;
    e.pt   = (m == 0) && btb[i].v && (btb[i].tag == m_pc[0] / 64) && (btb[i].cnt >= 2);
    e.ptgt = btb[i].tgt;
    e.link = D_PC + ((m == 1) ? 8 : 4);
    mis = (m == 0) && (r.ctl ? ((D_predTaken != r.tk) || (r.tk && D_predTarget != r.tgt))
                             : (D_valid && D_predTaken));
    e.flush = 0;
    if (X_redirect)   e.npc = X_target;
    else if (F_stall) e.npc = m_pc[m];
    else if (m == 1)  e.npc = r.tk ? r.tgt : m_pc[m] + 4;
    else if (mis) begin
      e.npc = r.tk ? r.tgt : D_PC + 4;
      e.flush = 1;
    end
    else if (e.pt)    e.npc = e.ptgt;
    else              e.npc = m_pc[m] + 4;
    return e;
  endfunction

  function automatic ent_t btb_new(ent_t o, res_t r, int unsigned tag);
    ent_t n = o;
    if (o.v && o.tag == tag) begin
      n.cnt = r.tk ? ((o.cnt < 3) ? o.cnt + 1 : 3) : ((o.cnt > 0) ? o.cnt - 1 : 0);
      if (r.tk) n.tgt = r.tgt;
    end else if (r.tk) begin
      n = '{v: 1'b1, tag: tag, tgt: r.tgt, cnt: 2};
    end
    return n;
  endfunction

  always_comb begin
    rr = resolve();
    x0 = model_out(0);
    x1 = model_out(1);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc[0] <= 32'h3000;
      m_pc[1] <= 32'h3000;
      for (int i = 0; i < 16; i++) btb[i] <= '{v: 1'b0, tag: 0, tgt: 0, cnt: 1};
    end else begin
      m_pc[0] <= x0.npc;
      m_pc[1] <= x1.npc;
      if (rr.ctl && !F_stall && !X_redirect)
        btb[(D_PC / 4) % 16] <= btb_new(btb[(D_PC / 4) % 16], rr, D_PC / 64);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("fpc_nd", o_pc[0], m_pc[0]);
    chk("fpc_ds", o_pc[1], m_pc[1]);
    chk("pt_nd", o_pt[0], x0.pt);
    chk("pt_ds", o_pt[1], 0);
    if (x0.pt) chk("ptgt_nd", o_ptgt[0], x0.ptgt);
    chk("flush_nd", o_fl[0], x0.flush);
    chk("flush_ds", o_fl[1], x1.flush);
    chk("link_nd", o_link[0], x0.link);
    chk("link_ds", o_link[1], x1.link);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_valid = 0; D_type = IT_NONE; D_isBranch = 0; D_imm = 0; D_RD1 = 0;
    D_predTaken = 0; D_predTarget = 0; D_PC = 0;
    F_stall = 0; X_redirect = 0; X_target = 0;
  endtask

  task automatic setd(logic [31:0] pc, logic [9:0] t, logic br, logic [25:0] imm,
                      logic [31:0] rd1, logic pt, logic [31:0] ptg);
    D_valid = 1; D_PC = pc; D_type = t; D_isBranch = br; D_imm = imm;
    D_RD1 = rd1; D_predTaken = pt; D_predTarget = ptg;
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("async_rst_nd", o_pc[0], 32'h3000);
    chk("async_rst_ds", o_pc[1], 32'h3000);
    chk("rst_pt", o_pt[0], 0);
    idle();
    cyc();
    reset = 0;
  endtask

  task automatic redirect(logic [31:0] a);
    idle();
    X_redirect = 1; X_target = a;
    cyc();
    idle();
    chk("redir_pc", o_pc[0], a);
  endtask

  task automatic loop_it(bit outc, bit exp_pt, bit exp_fl, logic [31:0] exp_pc);
    redirect(32'h3010);
    chk("loop_pt", o_pt[0], exp_pt);
    cyc();
    setd(32'h3010, IT_BEQ, outc, 26'd4, 0, exp_pt, exp_pt ? 32'h3024 : 32'h0);
    #1;
    chk("loop_flush", o_fl[0], exp_fl);
    cyc();
    chk("loop_pc", o_pc[0], exp_pc);
    idle();
  endtask

  initial begin
    #1;
    do_reset();
    chk("pc0", o_pc[0], 32'h3000);
    cyc(); chk("step1", o_pc[0], 32'h3004);
    cyc(); chk("step2", o_pc[1], 32'h3008);

    // delay-slot beq taken
    setd(32'h3000, IT_BEQ, 1, 26'h3, 0, 0, 0);
    #1;
    chk("ds_flush", o_fl[1], 0);
    chk("ds_link", o_link[1], 32'h3008);
    chk("nd_cold_flush", o_fl[0], 1);
    cyc();
    chk("ds_tgt", o_pc[1], 32'h3010);
    chk("nd_tgt", o_pc[0], 32'h3010);
    setd(32'h3010, IT_BSVEALL, 0, 26'h3, 0, 0, 0);
    cyc();
    chk("ds_bsv_nt", o_pc[1], 32'h3014);
    idle();

    // cold BTB beq at 0x3010 then re-fetch hit
    do_reset();
    repeat (5) cyc();
    chk("walk", o_pc[0], 32'h3014);
    setd(32'h3010, IT_BEQ, 1, 26'd4, 0, 0, 0);
    #1; chk("cold_flush", o_fl[0], 1);
    cyc(); chk("cold_pc", o_pc[0], 32'h3024);
    redirect(32'h3010);
    chk("hit_pt", o_pt[0], 1);
    chk("hit_tgt", o_ptgt[0], 32'h3024);
    cyc(); chk("pred_pc", o_pc[0], 32'h3024);
    setd(32'h3010, IT_BEQ, 1, 26'd4, 0, 1, 32'h3024);
    #1; chk("good_pred_flush", o_fl[0], 0);
    cyc(); chk("after_pred", o_pc[0], 32'h3028);
    idle();

    // loop branch: counter at 11 -> T, N, N
    loop_it(1, 1, 0, 32'h3028);
    loop_it(0, 1, 1, 32'h3014);
    loop_it(0, 1, 1, 32'h3014);
    redirect(32'h3010);
    chk("loop_final_pt", o_pt[0], 0);

    // redirect beats stall and mispredict
    F_stall = 1; X_redirect = 1; X_target = 32'h4180;
    setd(32'h3010, IT_BEQ, 1, 26'd4, 0, 0, 0);
    #1;
    chk("xr_flush_nd", o_fl[0], 0);
    chk("xr_flush_ds", o_fl[1], 0);
    cyc();
    chk("xr_pc_nd", o_pc[0], 32'h4180);
    chk("xr_pc_ds", o_pc[1], 32'h4180);
    redirect(32'h3010);
    chk("xr_btb_kept", o_pt[0], 0);

    // reset mid-stall, then alias eviction and stalled jr
    F_stall = 1;
    do_reset();
    setd(32'h3010, IT_JAL, 0, 26'hC40, 0, 0, 0);
    #1;
    chk("jal_flush", o_fl[0], 1);
    chk("jal_link_nd", o_link[0], 32'h3014);
    chk("jal_link_ds", o_link[1], 32'h3018);
    cyc();
    chk("jal_pc_nd", o_pc[0], 32'h3100);
    chk("jal_pc_ds", o_pc[1], 32'h3100);
    redirect(32'h3010);
    chk("jal_pt", o_pt[0], 1);
    chk("jal_ptgt", o_ptgt[0], 32'h3100);
    F_stall = 1;
    setd(32'h3050, IT_JR, 0, 0, 32'h3200, 0, 0);
    #1; chk("stall_flush", o_fl[0], 0);
    cyc(); chk("stall_pc1", o_pc[0], 32'h3010); chk("stall_pt1", o_pt[0], 1);
    cyc(); chk("stall_pc2", o_pc[0], 32'h3010); chk("stall_pt2", o_pt[0], 1);
    F_stall = 0;
    #1; chk("jr_flush", o_fl[0], 1);
    cyc(); chk("jr_pc", o_pc[0], 32'h3200);
    redirect(32'h3010);
    chk("evicted_pt", o_pt[0], 0);
    redirect(32'h3050);
    chk("alias_pt", o_pt[0], 1);
    chk("alias_tgt", o_ptgt[0], 32'h3200);
    cyc(); chk("alias_pred_pc", o_pc[0], 32'h3200);
    setd(32'h3050, IT_BEQ, 0, 26'd4, 0, 1, 32'h3200);
    #1; chk("nt_flush", o_fl[0], 1);
    cyc(); chk("nt_pc", o_pc[0], 32'h3054);
    redirect(32'h3050);
    chk("once_pt", o_pt[0], 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
